// File: rtl/karatsuba_divider.sv
// rtl/karatsuba_divider.sv - restoring radix-2 unsigned divider, 2N/N -> N quotient and remainder
module karatsuba_divider #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] C,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   Q,
    output logic [N-1:0]   R,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Partial remainder. It always stays below the divisor, so N bits hold it.
    logic [N-1:0]  rem;
    logic [N-1:0]  qsh;
    logic [CW-1:0] cnt;
    logic [N-1:0]  divisor;

    logic          accept;
    logic          b_zero;
    logic          b_ovf;
    logic [N:0]    t;
    logic          ge;
    logic [N-1:0]  diff;
    logic [N-1:0]  rem_step;
    logic [N-1:0]  qsh_step;

    assign accept = in_valid && (state == IDLE);
    assign b_zero = (B == '0);
    assign b_ovf  = (C[2*N-1:N] >= B);

    // The shifted remainder is N+1 bits wide so the compare never drops the carry.
    assign t        = {rem, qsh[N-1]};
    assign ge       = (t >= {1'b0, divisor});
    assign diff     = t[N-1:0] - divisor;
    assign rem_step = ge ? diff : t[N-1:0];
    assign qsh_step = {qsh[N-2:0], ge};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (b_zero || b_ovf) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one quotient bit per CALC cycle, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            qsh         <= '0;
            cnt         <= '0;
            divisor     <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (b_zero) begin
                            div_by_zero <= 1'b1;
                            Q           <= '1;
                            R           <= C[N-1:0];
                        end else if (b_ovf) begin
                            overflow <= 1'b1;
                            Q        <= '1;
                            R        <= C[N-1:0];
                        end else begin
                            rem     <= C[2*N-1:N];
                            qsh     <= C[N-1:0];
                            cnt     <= CW'(N - 1);
                            divisor <= B;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    qsh <= qsh_step;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        Q <= qsh_step;
                        R <= rem_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
